// File: rtl/bram_write_arbiter.sv
// Round-robin write-port arbiter for the frame BRAM with a built-in full-memory fill sequencer.
// Requester readies are combinational; every other output is registered.
module bram_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [14:0]      req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [14:0]      req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             clear_start,
  input  logic [WIDTH-1:0] clear_value,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             addr_err,
  output logic             bram_we,
  output logic [14:0]      bram_addr,
  output logic [WIDTH-1:0] bram_data
);

  localparam logic [0:0]  ST_ARB    = 1'b0;
  localparam logic [0:0]  ST_CLEAR  = 1'b1;
  localparam logic [15:0] DEPTH_EXT = 16'(DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [14:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] clr_val_q, clr_val_d;
  logic             bram_we_q, bram_we_d;
  logic [14:0]      bram_addr_q, bram_addr_d;
  logic [WIDTH-1:0] bram_data_q, bram_data_d;
  logic             clear_busy_q, clear_busy_d;
  logic             clear_done_q, clear_done_d;
  logic             addr_err_q, addr_err_d;

  logic             arb_open;
  logic             grant_any;
  logic [14:0]      grant_addr;
  logic [WIDTH-1:0] grant_data;

  // A pending clear blocks both requesters in the same cycle it is raised.
  assign arb_open   = rst_n && (state_q == ST_ARB) && !clear_start;
  assign req0_ready = arb_open && req0_valid && (!req1_valid || last_grant_q);
  assign req1_ready = arb_open && req1_valid && (!req0_valid || !last_grant_q);
  assign grant_any  = req0_ready || req1_ready;
  assign grant_addr = req1_ready ? req1_addr : req0_addr;
  assign grant_data = req1_ready ? req1_data : req0_data;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    clr_val_d    = clr_val_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_data_d  = bram_data_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    addr_err_d   = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          state_d      = ST_CLEAR;
          cnt_d        = '0;
          clr_val_d    = clear_value;
          bram_we_d    = 1'b1;
          bram_addr_d  = '0;
          bram_data_d  = clear_value;
          clear_busy_d = 1'b1;
        end else if (grant_any) begin
          last_grant_d = req1_ready;
          if ({1'b0, grant_addr} < DEPTH_EXT) begin
            bram_we_d   = 1'b1;
            bram_addr_d = grant_addr;
            bram_data_d = grant_data;
          end else begin
            addr_err_d  = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        // cnt_q is the address presented on the BRAM port this cycle.
        if (cnt_q == LAST_ADDR) begin
          state_d      = ST_ARB;
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + 15'd1;
          bram_we_d   = 1'b1;
          bram_addr_d = cnt_q + 15'd1;
          bram_data_d = clr_val_q;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      clr_val_q    <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      clr_val_q    <= clr_val_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_data  = bram_data_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign addr_err   = addr_err_q;

endmodule
